// File: rtl/pll_reset_sequencer.sv
// Purpose: sequence PLL reset, lock qualification and system reset release on the reference clock.
// Latency: lock_s trails pll_locked by 2 cycles; every output is registered (1 cycle after its cause).
// Backpressure: none; free-running control FSM, soft_reset restarts it from RESET_PLL.
//
// Ports:
//   clk          reference clock (same source as the PLL refclk)
//   reset_n      asynchronous active-low reset
//   pll_locked   PLL lock indication, asynchronous to clk
//   soft_reset   synchronous single-cycle restart request
//   pll_rst      active-high PLL reset
//   sys_reset_n  active-low system reset; asserts asynchronously, releases on the edge entering RUN
//   ready        high while in RUN
//   state        0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   retry_count  number of WAIT_LOCK timeouts, saturating at 15
//   lock_loss    sticky: lock dropped while in RUN
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [3:0] retry_count,
    output logic       lock_loss
);

    localparam int MAX_AB     = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                      : LOCK_STABLE_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic               loss_q, loss_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_reset_n_q;
    logic               ready_q, run_d;
    logic               lock_meta, lock_s;

    // Counter value on entry to each state; RUN has no terminal count.
    function automatic logic [CNT_W-1:0] load_value(input state_t s);
        case (s)
            ST_RESET_PLL: load_value = CNT_W'(PLL_RST_CYCLES);
            ST_WAIT_LOCK: load_value = CNT_W'(LOCK_TIMEOUT_CYCLES);
            ST_STABLE:    load_value = CNT_W'(LOCK_STABLE_CYCLES);
            default:      load_value = '0;
        endcase
    endfunction

    // Two-stage synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State register, counter, flags and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RESET_PLL;
            cnt_q         <= CNT_W'(PLL_RST_CYCLES);
            retry_q       <= 4'd0;
            loss_q        <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= run_d;
            ready_q       <= run_d;
        end
    end

    // Next-state logic. A count of 1 is the last cycle of a timed state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        cnt_d   = cnt_q;

        if (soft_reset) begin
            // Restart wins over everything, including a coincident lock drop in RUN.
            state_d = ST_RESET_PLL;
            retry_d = 4'd0;
            loss_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == CNT_W'(1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESET_PLL;
                        if (retry_q != 4'hf) retry_d = retry_q + 4'd1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s)                  state_d = ST_WAIT_LOCK;
                    else if (cnt_q == CNT_W'(1))  state_d = ST_RUN;
                end
                default: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        loss_d  = 1'b1;
                    end
                end
            endcase
        end

        // Reload on every state entry (soft_reset re-enters RESET_PLL even from RESET_PLL);
        // otherwise count down, holding at zero so the counter never wraps.
        if (soft_reset || (state_d != state_q)) begin
            cnt_d = load_value(state_d);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Output decode from the next state, so outputs change on the edge that enters a state.
    always_comb begin
        pll_rst_d = (state_d == ST_RESET_PLL);
        run_d     = (state_d == ST_RUN);
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign state       = state_q;
    assign retry_count = retry_q;
    assign lock_loss   = loss_q;

endmodule
